// File: rtl/vproc_vreg_wr_arb.sv
// Vector register file write-port arbiter.
// Round-robin arbitration among execution-unit write requesters. A multi-beat
// register-group burst locks the port to its owner until its last beat is taken.
// The write beat is registered, so there is one cycle of latency to the register file.
module vproc_vreg_wr_arb #(
   parameter int unsigned REQ_CNT = 8,
   parameter int unsigned VREG_W  = 128
) (
   input  logic                          clk_i,
   input  logic                          async_rst_ni,
   input  logic [REQ_CNT-1:0]            req_valid_i,
   output logic [REQ_CNT-1:0]            req_ready_o,
   input  logic [REQ_CNT-1:0]            req_last_i,
   input  logic [REQ_CNT*5-1:0]          req_addr_i,
   input  logic [REQ_CNT*VREG_W/8-1:0]   req_be_i,
   input  logic [REQ_CNT*VREG_W-1:0]     req_data_i,
   output logic                          wr_valid_o,
   input  logic                          wr_ready_i,
   output logic [4:0]                    wr_addr_o,
   output logic [VREG_W/8-1:0]           wr_be_o,
   output logic [VREG_W-1:0]             wr_data_o,
   output logic [$clog2(REQ_CNT)-1:0]    wr_src_o
);

   localparam int unsigned IDX_W  = $clog2(REQ_CNT);
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned BE_W   = VREG_W / 8;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [IDX_W-1:0]   r_lock_idx;
   logic [IDX_W-1:0]   w_lock_nxt;
   logic [IDX_W-1:0]   w_win;
   logic [IDX_W-1:0]   w_cand;
   logic               w_found;
   logic               w_out_free;
   logic               w_grant;
   logic               w_win_last;

   logic               r_wr_valid;
   logic [ADDR_W-1:0]  r_wr_addr;
   logic [BE_W-1:0]    r_wr_be;
   logic [VREG_W-1:0]  r_wr_data;
   logic [IDX_W-1:0]   r_wr_src;

   // Winner selection: lock owner when locked, else first valid at/after ptr
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      if (r_state == ST_LOCKED) begin
         w_win   = r_lock_idx;
         w_found = req_valid_i[r_lock_idx];
      end else begin
         for (int unsigned k = 0; k < REQ_CNT; k++) begin
            w_cand = IDX_W'((32'(r_ptr) + k) % REQ_CNT);
            if (!w_found && req_valid_i[w_cand]) begin
               w_found = 1'b1;
               w_win   = w_cand;
            end
         end
      end
   end

   // Grant only into a free output register; reset forces ready low immediately
   always_comb begin
      w_out_free  = !r_wr_valid || wr_ready_i;
      w_grant     = async_rst_ni && w_out_free && w_found;
      w_win_last  = req_last_i[w_win];
      req_ready_o = '0;
      if (w_grant) begin
         req_ready_o[w_win] = 1'b1;
      end
   end

   // Lock/pointer next-state: ptr moves only when a burst (or single beat) ends
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_lock_nxt  = r_lock_idx;
      if (w_grant) begin
         if (w_win_last) begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = IDX_W'((32'(w_win) + 32'd1) % REQ_CNT);
         end else begin
            w_state_nxt = ST_LOCKED;
            w_lock_nxt  = w_win;
         end
      end
   end

   // Arbitration state register
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_lock_idx <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_lock_idx <= w_lock_nxt;
      end
   end

   // Output valid: set on acceptance, cleared when consumed with nothing new
   always_ff @(posedge clk_i or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         r_wr_valid <= 1'b0;
      end else if (w_grant) begin
         r_wr_valid <= 1'b1;
      end else if (wr_ready_i) begin
         r_wr_valid <= 1'b0;
      end
   end

   // Payload capture of the accepted beat; holds otherwise
   always_ff @(posedge clk_i) begin
      if (w_grant) begin
         r_wr_addr <= req_addr_i[32'(w_win)*ADDR_W +: ADDR_W];
         r_wr_be   <= req_be_i[32'(w_win)*BE_W +: BE_W];
         r_wr_data <= req_data_i[32'(w_win)*VREG_W +: VREG_W];
         r_wr_src  <= w_win;
      end
   end

   assign wr_valid_o = r_wr_valid;
   assign wr_addr_o  = r_wr_addr;
   assign wr_be_o    = r_wr_be;
   assign wr_data_o  = r_wr_data;
   assign wr_src_o   = r_wr_src;

endmodule

// File: doc/vproc_vreg_wr_arb.md
VPROC_VREG_WR_ARB -- requirements
Module: vproc_vreg_wr_arb

Interface
REQ-001 Parameter REQ_CNT, default 8 (UNIT_CNT), number of execution-unit write requesters.
REQ-002 Parameter VREG_W, default 128, vector register write-port data width in bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 async_rst_ni  input  1  asynchronous active-low reset.
REQ-006 req_valid_i  input  REQ_CNT  per-requester write request valid.
REQ-007 req_ready_o  output  REQ_CNT  per-requester beat accepted (one-hot or zero).
REQ-008 req_last_i  input  REQ_CNT  per-requester final beat of a register-group burst.
REQ-009 req_addr_i  input  REQ_CNT*5  per-requester destination vreg address.
REQ-010 req_be_i  input  REQ_CNT*VREG_W/8  per-requester byte enables.
REQ-011 req_data_i  input  REQ_CNT*VREG_W  per-requester write data.
REQ-012 wr_valid_o  output  1  registered write to the vector register file.
REQ-013 wr_ready_i  input  1  register file accepts the write this cycle.
REQ-014 wr_addr_o  output  5  registered write address.
REQ-015 wr_be_o  output  VREG_W/8  registered byte enables.
REQ-016 wr_data_o  output  VREG_W  registered write data.
REQ-017 wr_src_o  output  $clog2(REQ_CNT)  index of the requester that produced the current output.

Function
REQ-018 The output register SHALL be free when wr_valid_o=0 or wr_ready_i=1 in the same cycle.
REQ-019 Arbitration SHALL be combinational and round-robin: the first valid requester at or after pointer ptr, with wrap from REQ_CNT-1 to 0, wins.
REQ-020 req_ready_o[w] SHALL be 1 only for winner w, and only when the output register is free; a beat is accepted when req_valid_i[w] and req_ready_o[w] are both 1.
REQ-021 An accepted beat SHALL appear on wr_*_o at the next clock edge: one cycle of latency, no combinational path from req_data_i to wr_data_o.
REQ-022 Output register contents SHALL hold stable while wr_valid_o=1 and wr_ready_i=0.
REQ-023 When the output is consumed and no beat is accepted, wr_valid_o SHALL drop to 0 at the next edge.
REQ-024 State machine states: IDLE (no lock) and LOCKED (burst owner held in lock_idx).
REQ-025 IDLE -> LOCKED on an accepted beat with req_last_i=0; lock_idx is set to the winner.
REQ-026 In LOCKED, only lock_idx SHALL be eligible for a grant; all other requesters see ready=0, even if lock_idx is not valid.
REQ-027 LOCKED -> IDLE on an accepted lock_idx beat with req_last_i=1.
REQ-028 ptr SHALL update to (winner+1) mod REQ_CNT only on an accepted beat with req_last_i=1; otherwise ptr holds.
REQ-029 A beat with last=1 accepted in IDLE SHALL be a single-beat transfer: state stays IDLE and ptr advances.
REQ-030 With no valid requester, or the output register not free, no grant SHALL be issued and state and ptr SHALL hold.
REQ-031 Simultaneous output drain (wr_ready_i=1) and new acceptance SHALL sustain one write per cycle with no bubble.
REQ-032 Payload registers (addr, be, data, src) MAY be left unreset; wr_valid_o, state, ptr and lock_idx SHALL be reset.

Reset
REQ-033 While async_rst_ni=0, the block SHALL hold wr_valid_o=0, req_ready_o=0, state=IDLE, ptr=0, lock_idx=0, independent of clk_i.
REQ-034 Reset asserted mid-burst SHALL immediately drop wr_valid_o and release the lock; the pending output beat is discarded.
REQ-035 After reset release, the first arbitration SHALL begin at ptr=0.

Verification
REQ-036 Single beat: wr_ready_i=1; req 2 valid, last=1, addr=5, data=0xA5.. -> ready_o[2]=1; the next cycle has wr_valid_o=1, addr 5, src 2; ptr=3.
REQ-037 Fairness: reqs 0, 3 and 7 held valid with last=1, wr_ready_i=1 -> grant order 0, 3, 7, 0, ... with one write per cycle and no bubbles.
REQ-038 Burst lock: req 1 sends 4 beats (last on beat 4) while req 0 is valid -> req 0 gets no ready until req 1's last is accepted; req 0 is granted on the following cycle.
REQ-039 Backpressure: wr_ready_i=0 for 3 cycles with output valid -> wr_*_o are stable, all req_ready_o=0; writes resume in the cycle wr_ready_i=1.
REQ-040 Locked owner idle: req 4 is locked and drops valid for 2 cycles while req 5 is valid -> req 5 is never granted until req 4 completes its last beat.
REQ-041 Reset mid-burst: assert async_rst_ni=0 asynchronously during a 3-beat burst -> wr_valid_o=0 immediately; after release, req 0 wins first when reqs 0 and 6 are both valid.
